// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer
// Wide adder (W = N*CHUNKS) built from one shared N-bit add slice. One chunk
// is added per cycle, least-significant first, with the carry chained through
// a register. Optional feature macro: SEQ_ADD_SUB_EN adds a `sub` port so the
// block computes a - b (b inverted, carry-in forced to 1).
//
// Handshake: a transfer happens on the rising clk edge where valid and ready
// are both high; the valid side holds its data stable until that edge, and
// ready never depends combinationally on valid.
//
// FSM state is exposed on dbg_state (0=IDLE, 1=CALC, 2=DONE).
module chunked_add_sequencer #(
    parameter int N      = 4,
    parameter int CHUNKS = 4,
    localparam int W     = N * CHUNKS,
    localparam int IW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [N-1:0]    w_a_chunk;
    logic [N-1:0]    w_b_chunk;
    logic [N:0]      w_chunk;
    logic [W-1:0]    w_b_in;
    logic            w_c_in;

    // Operand conditioning at capture time: subtraction is a + ~b + 1.
`ifdef SEQ_ADD_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    // Select the current chunk of each latched operand for the shared slice.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_chunk = r_a[k*N +: N];
                w_b_chunk = r_b[k*N +: N];
            end
        end
    end

    // The single N-bit add slice, widened to N+1 bits to produce the carry.
    assign w_chunk = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{N{1'b0}}, r_carry};

    // Control FSM with registered handshake/status outputs and datapath regs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= w_b_in;
                        r_carry    <= w_c_in;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    for (int k = 0; k < CHUNKS; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_sum[k*N +: N] <= w_chunk[N-1:0];
                        end
                    end
                    r_carry <= w_chunk[N];
                    if (r_idx == LAST_IDX) begin
                        // Index holds at the last chunk so it never wraps.
                        r_cout      <= w_chunk[N];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    // Going back through IDLE keeps the output handshake and
                    // the next acceptance in separate cycles.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Bench for chunked_add_sequencer: a 4x4-bit instance and a 1x8-bit instance.
// Drivers push hand-computed {cout,sum} into expected queues; monitors pop
// and compare on every output handshake and check acceptance-to-valid latency.
`timescale 1ns/1ps
module tb_chunked_add_sequencer;
  localparam int N0 = 4;
  localparam int C0 = 4;
  localparam int W0 = N0 * C0;
  localparam int N1 = 8;
  localparam int C1 = 1;
  localparam int W1 = N1 * C1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT 0: N=4, CHUNKS=4 ----------------
  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W0-1:0] a, b, sum;
  logic [1:0]    dbg_state;
`ifdef SEQ_ADD_SUB_EN
  logic          sub;
`endif

  chunked_add_sequencer #(.N(N0), .CHUNKS(C0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SEQ_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT 1: N=8, CHUNKS=1 ----------------
  logic          in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [W1-1:0] a1, b1, sum1;
  logic [1:0]    dbg_state1;
`ifdef SEQ_ADD_SUB_EN
  logic          sub1;
`endif

  chunked_add_sequencer #(.N(N1), .CHUNKS(C1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef SEQ_ADD_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard state ----------------
  logic [W0:0] exp_q[$];
  logic [W1:0] exp1_q[$];
  int          acc0_q[$];
  int          acc1_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitors ----------------
  logic        prev_ov0 = 1'b0;
  logic        prev_ov1 = 1'b0;
  logic [W0:0] e0;
  logic [W1:0] e1;
  int          t0, t1;

  // Monitor for DUT 0: latency on rising out_valid, result on handshake.
  always @(negedge clk) begin
    #2;
    if (out_valid && !prev_ov0) begin
      check("lat0_queue_nonempty", 32'(acc0_q.size() != 0), 1);
      if (acc0_q.size() != 0) begin
        t0 = acc0_q.pop_front();
        check("lat0_cycles", cyc - t0, C0);
      end
    end
    prev_ov0 = out_valid;
    if (out_valid && out_ready) begin
      check("sb0_queue_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e0 = exp_q.pop_front();
        check("sb0_sum", sum, e0[W0-1:0]);
        check("sb0_cout", cout, e0[W0]);
      end
    end
  end

  // Monitor for DUT 1.
  always @(negedge clk) begin
    #2;
    if (out_valid1 && !prev_ov1) begin
      check("lat1_queue_nonempty", 32'(acc1_q.size() != 0), 1);
      if (acc1_q.size() != 0) begin
        t1 = acc1_q.pop_front();
        check("lat1_cycles", cyc - t1, C1);
      end
    end
    prev_ov1 = out_valid1;
    if (out_valid1 && out_ready1) begin
      check("sb1_queue_nonempty", 32'(exp1_q.size() != 0), 1);
      if (exp1_q.size() != 0) begin
        e1 = exp1_q.pop_front();
        check("sb1_sum", sum1, e1[W1-1:0]);
        check("sb1_cout", cout1, e1[W1]);
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send0(input logic [W0-1:0] va, input logic [W0-1:0] vb, input logic vc,
                       input logic vs, input logic [W0-1:0] es, input logic ec,
                       input bit track, output int acc, output int waits);
    int n;
    a = va; b = vb; cin = vc;
`ifdef SEQ_ADD_SUB_EN
    sub = vs;
`else
    if (vs) $display("note: sub requested without SEQ_ADD_SUB_EN");
`endif
    in_valid = 1'b1;
    if (track) exp_q.push_back({ec, es});
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send0_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (track) acc0_q.push_back(cyc);
    in_valid = 1'b0;
    waits = n;
  endtask

  task automatic send1(input logic [W1-1:0] va, input logic [W1-1:0] vb, input logic vc,
                       input logic [W1-1:0] es, input logic ec);
    int n;
    a1 = va; b1 = vb; cin1 = vc;
    in_valid1 = 1'b1;
    exp1_q.push_back({ec, es});
    n = 0;
    while (!in_ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send1_in_ready", in_ready1, 1);
    @(posedge clk);
    @(negedge clk);
    acc1_q.push_back(cyc);
    in_valid1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size() + exp1_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int acc_a, acc_b, w, n, ov_seen;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
`ifdef SEQ_ADD_SUB_EN
    sub = 1'b0; sub1 = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_state", dbg_state, 0);
    check("rst1_in_ready", in_ready1, 1);
    check("rst1_out_valid", out_valid1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add, busy during CALC
    send0(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1, acc_a, w);
    check("calc_busy", busy, 1);
    check("calc_in_ready", in_ready, 0);
    check("calc_state", dbg_state, 1);
    drain();

    // Full carry ripple, back-to-back spacing
    send0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1, acc_a, w);
    send0(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1, acc_b, w);
    check("b2b_spacing", acc_b - acc_a, C0 + 2);
    send0(16'h8421, 16'h7BDE, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1, acc_a, w);
    drain();

    // Backpressure hold in DONE, new operands ignored until release
    out_ready = 1'b0;
    send0(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1, acc_a, w);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_reach_done", out_valid, 1);
    a = 16'h8000; b = 16'h8000; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_sum", sum, 16'h1000);
      check("hold_cout", cout, 0);
      check("hold_in_ready", in_ready, 0);
      check("hold_state", dbg_state, 2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send0(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1, acc_a, w);
    check("hold_release_accept_wait", w, 1);
    drain();

    // Reset in the middle of CALC
    send0(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 0, acc_a, w);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < C0 + 3; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("midrst_no_out_valid", ov_seen, 0);
    send0(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1, acc_a, w);
    drain();

`ifdef SEQ_ADD_SUB_EN
    // Subtraction; cin is ignored when sub=1
    send0(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1, acc_a, w);
    send0(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1, acc_a, w);
    send0(16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0, 1, acc_a, w);
    drain();
`endif

    // Single-chunk instance
    send1(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1);
    send1(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    send1(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    check("final_exp_q", exp_q.size(), 0);
    check("final_exp1_q", exp1_q.size(), 0);
    check("final_acc0_q", acc0_q.size(), 0);
    check("final_acc1_q", acc1_q.size(), 0);
    check("final_idle", dbg_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
